// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the lab CPU: streams the program into instruction
// memory, then alternates FETCH/EXEC, resolving halt > stall > jump > branch > +1.
module pc_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        load_valid,
  input  logic [DATA_WIDTH-1:0]       load_data,
  input  logic                        load_last,
  output logic                        imem_we,
  output logic [ADDR_WIDTH-1:0]       imem_waddr,
  output logic [DATA_WIDTH-1:0]       imem_wdata,
  output logic [ADDR_WIDTH:0]         load_count,
  input  logic [(2**ADDR_WIDTH)-1:0]  atual,
  output logic [(2**ADDR_WIDTH)-1:0]  proximo,
  output logic                        ir_load,
  input  logic                        jump,
  input  logic [(2**ADDR_WIDTH)-1:0]  jump_target,
  input  logic                        branch_taken,
  input  logic [(2**ADDR_WIDTH)-1:0]  branch_target,
  input  logic                        stall,
  input  logic                        halt_instr,
  output logic                        running,
  output logic                        halted
);

  localparam int PCW = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;
  localparam logic [PCW-1:0]      PC_ONE  = 1;

  typedef enum logic [2:0] {
    S_LOAD,
    S_WAIT_START,
    S_FETCH,
    S_EXEC,
    S_HALTED
  } state_t;

  state_t                  state, state_n;
  logic [PCW-1:0]          proximo_n;
  logic                    imem_we_n;
  logic [ADDR_WIDTH-1:0]   imem_waddr_n;
  logic [DATA_WIDTH-1:0]   imem_wdata_n;
  logic [ADDR_WIDTH:0]     load_count_n;
  logic                    ir_load_n;
  logic                    running_n;
  logic                    halted_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_LOAD;
      proximo    <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      load_count <= '0;
      ir_load    <= 1'b0;
      running    <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state      <= state_n;
      proximo    <= proximo_n;
      imem_we    <= imem_we_n;
      imem_waddr <= imem_waddr_n;
      imem_wdata <= imem_wdata_n;
      load_count <= load_count_n;
      ir_load    <= ir_load_n;
      running    <= running_n;
      halted     <= halted_n;
    end
  end

  always_comb begin
    state_n      = state;
    proximo_n    = proximo;
    imem_we_n    = 1'b0;
    imem_waddr_n = imem_waddr;
    imem_wdata_n = imem_wdata;
    load_count_n = load_count;

    case (state)
      S_LOAD: begin
        if (load_valid) begin
          imem_we_n    = 1'b1;
          imem_waddr_n = load_count[ADDR_WIDTH-1:0];
          imem_wdata_n = load_data;
          load_count_n = load_count + CNT_ONE;
          // Writing the top address ends the load even without load_last: no wrap.
          if (load_last || (load_count[ADDR_WIDTH-1:0] == '1)) begin
            state_n = S_WAIT_START;
          end
        end
      end

      S_WAIT_START: begin
        if (start) begin
          state_n   = S_FETCH;
          proximo_n = '0;
        end
      end

      S_FETCH: begin
        state_n = S_EXEC;
      end

      S_EXEC: begin
        if (halt_instr) begin
          proximo_n = atual;
          state_n   = S_HALTED;
        end else if (stall) begin
          state_n = S_EXEC;
        end else if (jump) begin
          proximo_n = jump_target;
          state_n   = S_FETCH;
        end else if (branch_taken) begin
          proximo_n = branch_target;
          state_n   = S_FETCH;
        end else begin
          proximo_n = atual + PC_ONE;
          state_n   = S_FETCH;
        end
      end

      S_HALTED: begin
        state_n = S_HALTED;
      end

      default: begin
        state_n = S_LOAD;
      end
    endcase

    // Status strobes are decoded from the next state so they line up with it.
    ir_load_n = (state_n == S_FETCH);
    running_n = (state_n == S_FETCH) || (state_n == S_EXEC);
    halted_n  = (state_n == S_HALTED);
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed load/run/halt/reset sequences, a table of EXEC
// decisions, and randomized programs checked against an instruction-level model.
module tb_pc_sequencer;

  localparam int DW  = 32;
  localparam int AW  = 6;
  localparam int PCW = 64;

  logic            clock = 1'b0;
  logic            reset, start, load_valid, load_last;
  logic [DW-1:0]   load_data;
  logic            imem_we;
  logic [AW-1:0]   imem_waddr;
  logic [DW-1:0]   imem_wdata;
  logic [AW:0]     load_count;
  logic [PCW-1:0]  atual, proximo, jump_target, branch_target;
  logic            ir_load, jump, branch_taken, stall, halt_instr, running, halted;

  // PC register model: samples proximo on the falling edge.
  logic            follow;
  logic [PCW-1:0]  pc_reg, atual_force;
  assign atual = follow ? pc_reg : atual_force;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;
  always @(negedge clock) pc_reg <= proximo;

  pc_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .start(start),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .load_count(load_count), .atual(atual), .proximo(proximo), .ir_load(ir_load),
    .jump(jump), .jump_target(jump_target), .branch_taken(branch_taken),
    .branch_target(branch_target), .stall(stall), .halt_instr(halt_instr),
    .running(running), .halted(halted)
  );

  typedef struct {
    logic [PCW-1:0] at;
    logic           h, s, j;
    logic [PCW-1:0] jt;
    logic           b;
    logic [PCW-1:0] bt;
    logic [PCW-1:0] e_px;
    logic           e_ir, e_run, e_halt;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; load_valid = 0; load_last = 0; load_data = '0;
    jump = 0; jump_target = '0; branch_taken = 0; branch_target = '0;
    stall = 0; halt_instr = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  // Reset, load one word, start; returns with the DUT in EXEC and proximo=0.
  task automatic go_exec();
    follow = 0;
    do_reset();
    load_valid = 1; load_last = 1; load_data = 32'hA5;
    step();
    load_valid = 0; load_last = 0; start = 1;
    step();
    start = 0;
    step();
  endtask

  function automatic logic [PCW-1:0] ref_next(input logic [PCW-1:0] pc, input logic j,
                                              input logic [PCW-1:0] jt, input logic b,
                                              input logic [PCW-1:0] bt);
    if (j) return jt;
    if (b) return bt;
    return pc + 64'd1;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    follow = 0; pc_reg = '0; atual_force = '0;
    reset = 1; clear_inputs();

    vecs[0] = '{64'd5,  1'b0, 1'b0, 1'b0, 64'd0,  1'b0, 64'd0,  64'd6,  1'b1, 1'b1, 1'b0};
    vecs[1] = '{64'd5,  1'b0, 1'b0, 1'b0, 64'd0,  1'b1, 64'd20, 64'd20, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{64'd5,  1'b0, 1'b0, 1'b1, 64'd40, 1'b1, 64'd20, 64'd40, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{'1,     1'b0, 1'b0, 1'b0, 64'd0,  1'b0, 64'd0,  64'd0,  1'b1, 1'b1, 1'b0};
    vecs[4] = '{64'd9,  1'b1, 1'b1, 1'b0, 64'd0,  1'b0, 64'd0,  64'd9,  1'b0, 1'b0, 1'b1};
    vecs[5] = '{64'd7,  1'b0, 1'b1, 1'b1, 64'd50, 1'b1, 64'd60, 64'd0,  1'b0, 1'b1, 1'b0};
    vecs[6] = '{64'd3,  1'b1, 1'b0, 1'b1, 64'd44, 1'b0, 64'd0,  64'd3,  1'b0, 1'b0, 1'b1};
    vecs[7] = '{64'd12, 1'b0, 1'b0, 1'b0, 64'd99, 1'b1, 64'd33, 64'd33, 1'b1, 1'b1, 1'b0};

    // Reset values
    step(); step();
    reset = 0;
    chk("rst_proximo", proximo, 0);
    chk("rst_we", imem_we, 0);
    chk("rst_waddr", imem_waddr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_count", load_count, 0);
    chk("rst_ir", ir_load, 0);
    chk("rst_running", running, 0);
    chk("rst_halted", halted, 0);

    // Three-word load with start held throughout
    start = 1;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1; load_data = 32'hA0 + i; load_last = (i == 2);
      step();
      chk("ld3_we", imem_we, 1);
      chk("ld3_waddr", imem_waddr, i);
      chk("ld3_wdata", imem_wdata, 32'hA0 + i);
      chk("ld3_running", running, 0);
      if (i == 0) begin
        load_valid = 0; load_last = 1;
        step();
        chk("ld3_gap_we", imem_we, 0);
      end
    end
    chk("ld3_count", load_count, 3);
    start = 0; load_valid = 1; load_last = 0;
    step();
    chk("wait_ignores_load", imem_we, 0);
    chk("wait_not_running", running, 0);
    load_valid = 0; start = 1;
    step();
    chk("start_running", running, 1);
    chk("start_ir", ir_load, 1);
    chk("start_proximo", proximo, 0);

    // Full 64-word load without load_last
    do_reset();
    for (int i = 0; i < 64; i++) begin
      load_valid = 1; load_data = 32'h1000 + i;
      step();
      chk("full_waddr", imem_waddr, i);
      chk("full_wdata", imem_wdata, 32'h1000 + i);
    end
    chk("full_count", load_count, 64);
    step();
    chk("full_65th_we", imem_we, 0);
    chk("full_count_hold", load_count, 64);
    load_valid = 0; start = 1;
    step();
    chk("full_start", running, 1);

    // Sequential run, then stall, then halt under stall
    do_reset();
    follow = 1;
    load_valid = 1; load_last = 1;
    step();
    load_valid = 0; load_last = 0; start = 1;
    step();
    start = 0;
    chk("seq_p0", proximo, 0);
    chk("seq_ir0", ir_load, 1);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("seq_exec_ir", ir_load, 0);
      chk("seq_exec_px", proximo, k - 1);
      step();
      chk("seq_fetch_ir", ir_load, 1);
      chk("seq_fetch_px", proximo, k);
    end
    step();
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_px", proximo, 3);
      chk("stall_ir", ir_load, 0);
      chk("stall_running", running, 1);
    end
    stall = 0;
    step();
    chk("resume_px", proximo, 4);
    chk("resume_ir", ir_load, 1);
    step();
    halt_instr = 1; stall = 1;
    step();
    chk("halt_px", proximo, 4);
    chk("halt_halted", halted, 1);
    chk("halt_running", running, 0);
    halt_instr = 0; stall = 0; start = 1; jump = 1; jump_target = 64'd77; load_valid = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("halted_hold_px", proximo, 4);
      chk("halted_hold", halted, 1);
      chk("halted_no_we", imem_we, 0);
    end

    // EXEC decision table
    for (int i = 0; i < 8; i++) begin
      go_exec();
      atual_force = vecs[i].at;
      halt_instr = vecs[i].h; stall = vecs[i].s;
      jump = vecs[i].j; jump_target = vecs[i].jt;
      branch_taken = vecs[i].b; branch_target = vecs[i].bt;
      step();
      chk("vec_proximo", proximo, vecs[i].e_px);
      chk("vec_ir", ir_load, vecs[i].e_ir);
      chk("vec_running", running, vecs[i].e_run);
      chk("vec_halted", halted, vecs[i].e_halt);
      clear_inputs();
    end

    // Reset during a stall, then reset during a load
    go_exec();
    atual_force = 64'd5; stall = 1;
    step(); step();
    reset = 1;
    step();
    reset = 0;
    chk("rstrun_px", proximo, 0);
    chk("rstrun_running", running, 0);
    chk("rstrun_ir", ir_load, 0);
    chk("rstrun_count", load_count, 0);
    stall = 0; load_valid = 1; load_data = 32'h55;
    step();
    chk("rstrun_load_we", imem_we, 1);
    chk("rstrun_load_addr", imem_waddr, 0);
    chk("rstrun_load_data", imem_wdata, 32'h55);
    reset = 1;
    step();
    reset = 0;
    chk("rstload_we", imem_we, 0);
    chk("rstload_count", load_count, 0);

    // Randomized programs against the instruction-level model
    for (int prog = 0; prog < 6; prog++) begin
      int unsigned len, cnt, guard;
      logic use_last, v;
      logic [DW-1:0] d;
      logic [PCW-1:0] m_pc, jt, bt;
      logic h, s, j, b;
      follow = 0;
      do_reset();
      len = $urandom_range(1, 64);
      use_last = (len < 64) ? 1'b1 : 1'($urandom_range(0, 1));
      cnt = 0; guard = 0;
      while (cnt < len && guard < 400) begin
        v = ($urandom_range(0, 3) != 0);
        d = $urandom;
        load_valid = v; load_data = d;
        load_last = v ? (use_last && (cnt == len - 1)) : 1'($urandom_range(0, 1));
        step();
        chk("rnd_we", imem_we, v);
        if (v) begin
          chk("rnd_waddr", imem_waddr, cnt);
          chk("rnd_wdata", imem_wdata, d);
          cnt++;
        end
        guard++;
      end
      chk("rnd_count", load_count, len);
      load_valid = 1; load_last = 0;
      step();
      chk("rnd_wait_we", imem_we, 0);
      load_valid = 0;
      follow = 1; start = 1;
      step();
      start = 0;
      m_pc = '0;
      chk("rnd_start_px", proximo, m_pc);
      step();
      for (int n = 0; n < 20; n++) begin
        for (int k = $urandom_range(0, 2); k > 0; k--) begin
          stall = 1; jump = 1'($urandom_range(0, 1)); branch_taken = 1'($urandom_range(0, 1));
          jump_target = {$urandom, $urandom}; branch_target = {$urandom, $urandom};
          step();
          chk("rnd_stall_px", proximo, m_pc);
          chk("rnd_stall_ir", ir_load, 0);
        end
        h = (n == 19) || ($urandom_range(0, 15) == 0);
        s = h ? 1'($urandom_range(0, 1)) : 1'b0;
        j = 1'($urandom_range(0, 1)); b = 1'($urandom_range(0, 1));
        jt = {$urandom, $urandom}; bt = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) jt = '1;
        halt_instr = h; stall = s; jump = j; branch_taken = b;
        jump_target = jt; branch_target = bt;
        step();
        clear_inputs();
        if (h) begin
          chk("rnd_halt_px", proximo, m_pc);
          chk("rnd_halted", halted, 1);
          start = 1; jump = 1;
          step();
          chk("rnd_halt_hold", proximo, m_pc);
          clear_inputs();
          break;
        end
        m_pc = ref_next(m_pc, j, jt, b, bt);
        chk("rnd_px", proximo, m_pc);
        chk("rnd_ir", ir_load, 1);
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
